workers_cpu_3_cpu_mul_seq: RTL and testbench

Multiply sequencer for the CPU's 16x16 multiplier cell: takes one 32x32 unsigned multiply request at a time, drives the cell's operands and enable, and recombines the three (optionally four) partial products into a 32-bit result. It sits between the execute stage and the multiplier cell.
- Low word (`mul`) takes one cell pass.
- High word (`mulxuu`, with `MUL_HIGH_EN`) takes a second pass to obtain a_hi*b_hi.

---
 rtl/workers_cpu_3_cpu_mul_seq.sv | 96 +++++++++
 tb/tb_workers_cpu_3_cpu_mul_seq.sv | 137 +++++++++++++
 2 files changed

// File: rtl/workers_cpu_3_cpu_mul_seq.sv
// workers_cpu_3_cpu_mul_seq: 32x32 unsigned multiply sequencer over a 16x16 partial-product cell.
// Define MUL_HIGH_EN to add the second cell pass that returns product bits [63:32].
module workers_cpu_3_cpu_mul_seq (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  input  logic        req_high,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [31:0] cell_src1,
  output logic [31:0] cell_src2,
  output logic        cell_en,
  input  logic [31:0] cell_p1,
  input  logic [31:0] cell_p2,
  input  logic [31:0] cell_p3
);
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] ISSUE_LO = 3'd1;
  localparam logic [2:0] CAP_LO   = 3'd2;
  localparam logic [2:0] RESP     = 3'd5;
`ifdef MUL_HIGH_EN
  localparam logic [2:0] ISSUE_HI = 3'd3;
  localparam logic [2:0] CAP_HI   = 3'd4;
`endif
  logic [2:0]  state;
  logic [31:0] a_r, b_r;
  logic [32:0] mid, sum_lo;
  assign mid = {1'b0, cell_p2} + {1'b0, cell_p3};
  assign sum_lo = {1'b0, cell_p1} + {1'b0, mid[15:0], 16'h0};
  assign req_ready = (state == IDLE) & reset_n;
  assign rsp_valid = state == RESP;
`ifdef MUL_HIGH_EN
  logic        high_r, c;
  logic [16:0] mid_hi;
  assign cell_en = (state == ISSUE_LO) | (state == ISSUE_HI);
  assign cell_src1 = state == ISSUE_LO ? a_r : state == ISSUE_HI ? {16'h0, a_r[31:16]} : 32'h0;
  assign cell_src2 = state == ISSUE_LO ? b_r : state == ISSUE_HI ? {16'h0, b_r[31:16]} : 32'h0;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      high_r <= 1'b0;
      c      <= 1'b0;
      mid_hi <= '0;
    end else if (state == IDLE && req_valid) begin
      high_r <= req_high;
    end else if (state == CAP_LO) begin
      mid_hi <= mid[32:16];
      c      <= sum_lo[32];
    end
`else
  logic unused;
  assign unused = ^{req_high, mid[32:16], sum_lo[32]};
  assign cell_en = state == ISSUE_LO;
  assign cell_src1 = cell_en ? a_r : 32'h0;
  assign cell_src2 = cell_en ? b_r : 32'h0;
`endif
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state      <= IDLE;
      a_r        <= '0;
      b_r        <= '0;
      rsp_result <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          a_r   <= req_src1;
          b_r   <= req_src2;
          state <= ISSUE_LO;
        end
        ISSUE_LO: state <= CAP_LO;
`ifdef MUL_HIGH_EN
        CAP_LO: if (high_r) state <= ISSUE_HI;
        else begin
          rsp_result <= sum_lo[31:0];
          state      <= RESP;
        end
        ISSUE_HI: state <= CAP_HI;
        // high pass: p1 now holds a_hi*b_hi; fold in the carried middle terms
        CAP_HI: begin
          rsp_result <= cell_p1 + {15'h0, mid_hi} + {31'h0, c};
          state      <= RESP;
        end
`else
        CAP_LO: begin
          rsp_result <= sum_lo[31:0];
          state      <= RESP;
        end
`endif
        RESP: if (rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_workers_cpu_3_cpu_mul_seq.sv
// tb_workers_cpu_3_cpu_mul_seq: scoreboard bench with a behavioural 16x16 cell model.
module tb_workers_cpu_3_cpu_mul_seq;
`ifdef MUL_HIGH_EN
  localparam bit HE = 1'b1;
`else
  localparam bit HE = 1'b0;
`endif
  logic clk = 0, reset_n = 0, req_valid = 0, req_high = 0, rsp_ready = 1;
  logic [31:0] req_src1 = 0, req_src2 = 0;
  logic req_ready, rsp_valid, cell_en;
  logic [31:0] rsp_result, cell_src1, cell_src2;
  logic [31:0] cell_p1, cell_p2, cell_p3;
  int cyc = 0, n_pass = 0, n_total = 0;
  logic [63:0] q[$];

  workers_cpu_3_cpu_mul_seq dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_src1(req_src1), .req_src2(req_src2), .req_high(req_high),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .cell_src1(cell_src1), .cell_src2(cell_src2), .cell_en(cell_en),
    .cell_p1(cell_p1), .cell_p2(cell_p2), .cell_p3(cell_p3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cell_p1 <= 0; cell_p2 <= 0; cell_p3 <= 0;
    end else if (cell_en) begin
      cell_p1 <= cell_src1[15:0] * cell_src2[15:0];
      cell_p2 <= cell_src1[15:0] * cell_src2[31:16];
      cell_p3 <= cell_src1[31:16] * cell_src2[15:0];
    end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // monitor: pops one expectation per response and checks it is held under backpressure
  logic in_rsp = 0;
  logic [31:0] held;
  always @(negedge clk) begin
    if (!reset_n || !rsp_valid) in_rsp = 0;
    else if (!in_rsp) begin
      in_rsp = 1;
      held = rsp_result;
      if (q.size() == 0) chk("rsp_unexpected", 1, 0);
      else begin
        logic [63:0] e;
        e = q.pop_front();
        chk("rsp_result", rsp_result, e[63:32]);
        chk("rsp_cycle", cyc, e[31:0]);
      end
    end else begin
      chk("rsp_hold", rsp_result, held);
      chk("rsp_req_ready", {31'h0, req_ready}, 0);
      chk("rsp_cell_en", {31'h0, cell_en}, 0);
    end
  end

  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic hi,
                     input logic [31:0] exp, input int stall);
    int lat;
    logic he;
    he = hi & HE;
    lat = he ? 5 : 3;
    rsp_ready = (stall == 0);
    chk("req_ready_idle", {31'h0, req_ready}, 1);
    req_valid = 1; req_src1 = a; req_src2 = b; req_high = hi;
    q.push_back({exp, cyc + lat});
    @(negedge clk);
    req_valid = 0; req_src1 = $urandom; req_src2 = $urandom; req_high = $urandom;
    for (int k = 1; k < lat; k++) begin
      chk("cell_en", {31'h0, cell_en}, {31'h0, k == 1 || (he && k == 3)});
      chk("cell_src1", cell_src1, k == 1 ? a : (he && k == 3) ? {16'h0, a[31:16]} : 32'h0);
      chk("cell_src2", cell_src2, k == 1 ? b : (he && k == 3) ? {16'h0, b[31:16]} : 32'h0);
      @(negedge clk);
    end
    if (stall > 0) begin
      repeat (stall) @(negedge clk);
      rsp_ready = 1;
      chk("stall_rsp_valid", {31'h0, rsp_valid}, 1);
    end
    chk("req_ready_busy", {31'h0, req_ready}, 0);
    @(negedge clk);
    chk("req_ready_after", {31'h0, req_ready}, 1);
    chk("rsp_valid_after", {31'h0, rsp_valid}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'h0, req_ready}, 0);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_cell_en", {31'h0, cell_en}, 0);
    chk("rst_cell_src", cell_src1 | cell_src2, 0);
    reset_n = 1;
    @(negedge clk);
    run(32'h00010003, 32'h00020005, 0, 32'h000B000F, 0);
    run(32'h00010003, 32'h00020005, 1, HE ? 32'h00000002 : 32'h000B000F, 0);
    run(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'h00000001, 0);
    run(32'hFFFFFFFF, 32'hFFFFFFFF, 1, HE ? 32'hFFFFFFFE : 32'h00000001, 0);
    run(32'h0000FFFF, 32'h00010000, 0, 32'hFFFF0000, 0);
    run(32'h80000000, 32'h00000002, 1, HE ? 32'h00000001 : 32'h00000000, 0);
    run(32'h00010003, 32'h00020005, 0, 32'h000B000F, 4);
    // abort a high request mid-flight (during ISSUE_HI, or CAP_LO when single-pass)
    req_valid = 1; req_src1 = 32'h12345678; req_src2 = 32'h9ABCDEF0; req_high = 1;
    @(negedge clk);
    req_valid = 0;
    repeat (HE ? 2 : 1) @(negedge clk);
    reset_n = 0;
    #1;
    chk("abort_req_ready", {31'h0, req_ready}, 0);
    chk("abort_cell_en", {31'h0, cell_en}, 0);
    chk("abort_rsp_result", rsp_result, 0);
    @(negedge clk);
    reset_n = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_no_rsp", {31'h0, rsp_valid}, 0);
    end
    run(32'h00000002, 32'h00000003, 0, 32'h00000006, 0);
    repeat (2) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
